// File: rtl/tcdm_rob_port.sv
// Reorder-buffer port between one core LSU and one initiator port of the
// variable-latency TCDM interconnect. Requests are tagged with a slot index;
// out-of-order network responses are parked in their slot and retired to the
// core strictly in issue order.
module tcdm_rob_port #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned NumOutstanding = 8,
  localparam int unsigned TagWidth      = $clog2(NumOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Core side
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] add_i,
  input  logic                 wen_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 vld_o,
  input  logic                 rdy_i,
  output logic [DataWidth-1:0] rdata_o,
  // Network side
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  output logic [TagWidth-1:0]  tag_o,
  input  logic                 vld_i,
  output logic                 rdy_o,
  input  logic [TagWidth-1:0]  tag_i,
  input  logic [DataWidth-1:0] rdata_i,
  // Status
  output logic [TagWidth:0]    outstanding_o
);

  localparam logic [TagWidth:0] FullCount = (TagWidth + 1)'(NumOutstanding);
  localparam logic [TagWidth:0] PtrOne    = (TagWidth + 1)'(1);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [TagWidth:0]          wr_ptr_q, wr_ptr_d;
  logic [TagWidth:0]          rd_ptr_q, rd_ptr_d;
  logic [NumOutstanding-1:0]  done_q, done_d;
  logic [DataWidth-1:0]       data_q [NumOutstanding];

  logic [TagWidth-1:0] rd_slot;
  logic                full, empty;
  logic                alloc, retire;

  assign outstanding_o = wr_ptr_q - rd_ptr_q;
  assign full          = (outstanding_o == FullCount);
  assign empty         = (outstanding_o == '0);
  assign rd_slot       = rd_ptr_q[TagWidth-1:0];

  // Request path: pure pass-through gated only by the registered full flag,
  // so there is no combinational path from rdy_i to gnt_o.
  assign req_o   = req_i & ~full;
  assign gnt_o   = gnt_i & ~full;
  assign add_o   = add_i;
  assign wen_o   = wen_i;
  assign wdata_o = wdata_i;
  assign be_o    = be_i;
  assign tag_o   = wr_ptr_q[TagWidth-1:0];

  // A slot is reserved at issue, so a response can always be accepted.
  assign rdy_o   = 1'b1;

  // Retire side is driven from registers only (no vld_i bypass).
  assign vld_o   = ~empty & done_q[rd_slot];
  assign rdata_o = data_q[rd_slot];

  assign alloc   = req_o & gnt_i;
  assign retire  = vld_o & rdy_i;

  // Next-state for pointers and done bits; the three updates hit distinct
  // slots in any legal cycle, so their order only matters for illegal input.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = done_q;
    if (retire) begin
      done_d[rd_slot] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PtrOne;
    end
    if (vld_i) begin
      done_d[tag_i] = 1'b1;
    end
    if (alloc) begin
      done_d[tag_o] = 1'b0;
      wr_ptr_d      = wr_ptr_q + PtrOne;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // Response data capture; contents are qualified by done_q, so no reset.
  always_ff @(posedge clk_i) begin
    if (vld_i) begin
      data_q[tag_i] <= rdata_i;
    end
  end

  // Protocol checks on the network response channel.
  logic [TagWidth-1:0] resp_offset;
  assign resp_offset = tag_i - rd_slot;

  a_resp_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    vld_i |-> !empty);
  a_resp_allocated : assert property (@(posedge clk_i) disable iff (!rst_ni)
    vld_i |-> ({1'b0, resp_offset} < outstanding_o));
  a_resp_not_done  : assert property (@(posedge clk_i) disable iff (!rst_ni)
    vld_i |-> !done_q[tag_i]);

endmodule

// File: tb/tb_tcdm_rob_port.sv
// Bench for tcdm_rob_port: directed scenarios with literal expectations plus a
// queue-based model of issue order checked against the DUT every cycle.
module tb_tcdm_rob_port;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, gnt = 1'b0, wen = 1'b0, rdy = 1'b1;
  logic [31:0] add = '0, wdata = '0, nrdata = '0;
  logic [3:0]  be = '0;
  logic        nvld = 1'b0;
  logic [2:0]  ntag = '0;

  logic        gnt_o, vld_o, req_o, wen_o, rdy_o;
  logic [31:0] rdata_o, add_o, wdata_o;
  logic [3:0]  be_o;
  logic [2:0]  tag_o;
  logic [3:0]  outstanding_o;

  tcdm_rob_port dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt_o),
    .add_i         (add),
    .wen_i         (wen),
    .wdata_i       (wdata),
    .be_i          (be),
    .vld_o         (vld_o),
    .rdy_i         (rdy),
    .rdata_o       (rdata_o),
    .req_o         (req_o),
    .gnt_i         (gnt),
    .add_o         (add_o),
    .wen_o         (wen_o),
    .wdata_o       (wdata_o),
    .be_o          (be_o),
    .tag_o         (tag_o),
    .vld_i         (nvld),
    .rdy_o         (rdy_o),
    .tag_i         (ntag),
    .rdata_i       (nrdata),
    .outstanding_o (outstanding_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: tags in issue order, per-tag arrival flag and data.
  int          mq[$];
  bit          arr[N];
  logic [31:0] md[N];
  int          next_tag;
  bit          m_ret, m_iss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      next_tag = 0;
      for (int i = 0; i < N; i++) arr[i] = 1'b0;
    end else begin
      m_ret = (mq.size() > 0) && arr[mq[0]] && rdy;
      m_iss = req && gnt && (mq.size() < N);
      if (m_ret) begin
        arr[mq[0]] = 1'b0;
        void'(mq.pop_front());
      end
      if (nvld) begin
        arr[ntag] = 1'b1;
        md[ntag]  = nrdata;
      end
      if (m_iss) begin
        mq.push_back(next_tag);
        next_tag = (next_tag + 1) % N;
      end
    end
  end

  // Every-cycle compare against the model; also logs data handed to the core.
  logic [31:0] got[$];
  bit          e_vld, e_room;

  always @(negedge clk) begin
    if (rst_n) begin
      e_room = (mq.size() < N);
      e_vld  = (mq.size() > 0) && arr[mq[0]];
      chk("vld_o", vld_o, e_vld);
      if (e_vld) chk("rdata_o", rdata_o, md[mq[0]]);
      chk("outstanding_o", outstanding_o, mq.size());
      chk("gnt_o", gnt_o, gnt && e_room);
      chk("req_o", req_o, req && e_room);
      chk("tag_o", tag_o, next_tag);
      chk("rdy_o", rdy_o, 1'b1);
      chk("passthru", {add_o, wen_o, wdata_o, be_o}, {add, wen, wdata, be});
      if (vld_o && rdy) got.push_back(rdata_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0; gnt = 1'b0; nvld = 1'b0; rdy = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  int          p_tag[$];
  int          p_due[$];
  logic [31:0] p_dat[$];
  logic [31:0] exp_data[$];
  int          issued;

  initial begin
    // Reset values
    gnt = 1'b1;
    #3;
    chk("rst_gnt_follows", gnt_o, 1'b1);
    chk("rst_vld", vld_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_rdy", rdy_o, 1'b1);
    chk("rst_tag", tag_o, 0);
    do_reset();

    // Single read in order
    req = 1'b1; gnt = 1'b1; add = 32'h1000_0040; wen = 1'b0; be = 4'hf;
    #2; chk("single_tag", tag_o, 0); chk("single_gnt", gnt_o, 1'b1);
    step();
    req = 1'b0;
    #2; chk("single_out1", outstanding_o, 1);
    step();
    nvld = 1'b1; ntag = 3'd0; nrdata = 32'hA5A5_0001;
    #2; chk("single_no_bypass", vld_o, 1'b0);
    step();
    nvld = 1'b0;
    #2; chk("single_vld", vld_o, 1'b1); chk("single_data", rdata_o, 32'hA5A5_0001);
    step();
    #2; chk("single_out0", outstanding_o, 0); chk("single_vld_off", vld_o, 1'b0);

    // Reordering: tags 0,1,2 answered 2,0,1
    do_reset();
    got.delete();
    req = 1'b1; gnt = 1'b1;
    repeat (3) step();
    req = 1'b0;
    nvld = 1'b1; ntag = 3'd2; nrdata = 32'h22;
    step();
    ntag = 3'd0; nrdata = 32'h00;
    #2; chk("reorder_hold", vld_o, 1'b0);
    step();
    ntag = 3'd1; nrdata = 32'h11;
    #2; chk("reorder_first_vld", vld_o, 1'b1); chk("reorder_first", rdata_o, 32'h00);
    step();
    nvld = 1'b0;
    repeat (4) step();
    chk("reorder_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("reorder_0", got[0], 32'h00);
      chk("reorder_1", got[1], 32'h11);
      chk("reorder_2", got[2], 32'h22);
    end

    // Full
    do_reset();
    req = 1'b1; gnt = 1'b1;
    repeat (8) step();
    #2;
    chk("full_out", outstanding_o, 8); chk("full_gnt", gnt_o, 1'b0); chk("full_req", req_o, 1'b0);
    nvld = 1'b1; ntag = 3'd0; nrdata = 32'h5;
    step();
    nvld = 1'b0;
    #2; chk("full_retire_vld", vld_o, 1'b1); chk("full_no_rdy_gnt_path", gnt_o, 1'b0);
    step();
    #2; chk("full_regnt", gnt_o, 1'b1); chk("full_regnt_tag", tag_o, 0);
    chk("full_out7", outstanding_o, 7);
    step();
    req = 1'b0;
    step();

    // Backpressure
    do_reset();
    req = 1'b1; gnt = 1'b1;
    repeat (8) step();
    req = 1'b0; rdy = 1'b0;
    for (int t = 7; t >= 0; t--) begin
      nvld = 1'b1; ntag = 3'(t); nrdata = 32'h100 + 32'(t);
      step();
    end
    nvld = 1'b0;
    got.delete();
    repeat (10) begin
      #2; chk("bp_hold_vld", vld_o, 1'b1); chk("bp_hold_data", rdata_o, 32'h100);
      step();
    end
    rdy = 1'b1;
    repeat (8) begin
      #2; chk("bp_b2b_vld", vld_o, 1'b1);
      step();
    end
    #2; chk("bp_out0", outstanding_o, 0); chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", got[i], 32'h100 + 32'(i));

    // Wrap with random latency and random grant/ready
    do_reset();
    got.delete(); exp_data.delete(); p_tag.delete(); p_due.delete(); p_dat.delete();
    issued = 0;
    for (int c = 0; c < 160; c++) begin
      req   = (c < 60);
      gnt   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 4) != 0);
      wen   = 1'($urandom_range(0, 1));
      add   = $urandom();
      wdata = $urandom();
      be    = 4'($urandom_range(0, 15));
      if (req && gnt && mq.size() < N) begin
        p_tag.push_back(next_tag);
        p_due.push_back(c + int'($urandom_range(1, 6)));
        p_dat.push_back(32'hC000_0000 + 32'(issued));
        exp_data.push_back(32'hC000_0000 + 32'(issued));
        issued++;
      end
      nvld = 1'b0;
      for (int i = 0; i < p_tag.size(); i++) begin
        if (p_due[i] <= c) begin
          nvld = 1'b1; ntag = 3'(p_tag[i]); nrdata = p_dat[i];
          p_tag.delete(i); p_due.delete(i); p_dat.delete(i);
          break;
        end
      end
      step();
    end
    nvld = 1'b0; req = 1'b0; rdy = 1'b1;
    step();
    chk("wrap_count", got.size(), exp_data.size());
    for (int i = 0; i < got.size() && i < exp_data.size(); i++)
      chk("wrap_order", got[i], exp_data[i]);
    chk("wrap_drained", outstanding_o, 0);

    // Reset mid-stream
    do_reset();
    req = 1'b1; gnt = 1'b1;
    repeat (5) step();
    req = 1'b0;
    nvld = 1'b1; ntag = 3'd0; nrdata = 32'h77;
    step();
    nvld = 1'b0;
    #2; chk("mid_pre_vld", vld_o, 1'b1); chk("mid_pre_out", outstanding_o, 5);
    rst_n = 1'b0;
    #1; chk("mid_rst_out", outstanding_o, 0); chk("mid_rst_vld", vld_o, 1'b0);
    step(); step();
    rst_n = 1'b1; req = 1'b1; gnt = 1'b1;
    #2; chk("mid_post_tag", tag_o, 0);
    step();
    req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
